// File: rtl/cpu_pkg.sv
// Shared types and constants for the program sequencer: opcodes, FSM states,
// instruction field positions and the decoded control bundle.
package cpu_pkg;

    localparam int PC_W    = 3;
    localparam int INSTR_W = 12;
    localparam int DADDR_W = 4;
    localparam int RF_AW   = 3;
    localparam int IMM_W   = 4;

    // Field positions in the 12-bit instruction word
    localparam int OPC_HI = 11;
    localparam int OPC_LO = 9;
    localparam int RD_HI  = 8;
    localparam int RD_LO  = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 3;
    localparam int RT_HI  = 2;
    localparam int RT_LO  = 0;
    localparam int MR_HI  = 6;
    localparam int MR_LO  = 4;
    localparam int MA_HI  = 3;
    localparam int MA_LO  = 0;

    typedef enum logic [2:0] {
        LOAD  = 3'b000,
        STORE = 3'b001,
        SUB   = 3'b010,
        ADD   = 3'b011,
        ADDI  = 3'b101,
        JMP   = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [RF_AW-1:0]   rf_raddr_a;
        logic [RF_AW-1:0]   rf_raddr_b;
        logic [RF_AW-1:0]   rf_waddr;
        logic               rf_wsrc;
        logic               alu_op;
        logic               alu_b_imm;
        logic [IMM_W-1:0]   imm;
        logic [DADDR_W-1:0] dm_addr;
    } dp_t;

    typedef struct packed {
        dp_t             dp;
        logic            dm_we;
        logic            rf_we;
        logic            jump;
        logic [PC_W-1:0] jmp_target;
        logic            illegal;
    } ctrl_t;

    localparam dp_t   DP_IDLE   = '0;
    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc_v);
        return pc_v + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: maps an instruction word onto the
// datapath selects and the strobe/branch intent of that instruction.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output ctrl_t              ctrl_o
);

    logic [2:0] opc_d;

    assign opc_d = instr_i[OPC_HI:OPC_LO];

    // Decode opcode into control bundle; unlisted fields stay at zero
    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (opc_d)
            LOAD: begin
                ctrl_o.dp.rf_waddr = instr_i[MR_HI:MR_LO];
                ctrl_o.dp.dm_addr  = instr_i[MA_HI:MA_LO];
                ctrl_o.dp.rf_wsrc  = 1'b0;
                ctrl_o.rf_we       = 1'b1;
            end
            STORE: begin
                ctrl_o.dp.rf_raddr_a = instr_i[MR_HI:MR_LO];
                ctrl_o.dp.dm_addr    = instr_i[MA_HI:MA_LO];
                ctrl_o.dm_we         = 1'b1;
            end
            SUB, ADD: begin
                ctrl_o.dp.rf_waddr   = instr_i[RD_HI:RD_LO];
                ctrl_o.dp.rf_raddr_a = instr_i[RS_HI:RS_LO];
                ctrl_o.dp.rf_raddr_b = instr_i[RT_HI:RT_LO];
                ctrl_o.dp.alu_op     = (opc_d == SUB) ? 1'b1 : 1'b0;
                ctrl_o.dp.rf_wsrc    = 1'b1;
                ctrl_o.rf_we         = 1'b1;
            end
            ADDI: begin
                ctrl_o.dp.rf_waddr   = instr_i[RD_HI:RD_LO];
                ctrl_o.dp.rf_raddr_a = instr_i[RS_HI:RS_LO];
                ctrl_o.dp.imm        = {1'b0, instr_i[RT_HI:RT_LO]};
                ctrl_o.dp.alu_b_imm  = 1'b1;
                ctrl_o.dp.alu_op     = 1'b0;
                ctrl_o.dp.rf_wsrc    = 1'b1;
                ctrl_o.rf_we         = 1'b1;
            end
            JMP: begin
                ctrl_o.jump       = 1'b1;
                ctrl_o.jmp_target = instr_i[RT_HI:RT_LO];
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for an 8-entry program
// with registered control strobes and a sticky illegal-opcode halt.
module program_sequencer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc,
    output logic [RF_AW-1:0]   rf_raddr_a,
    output logic [RF_AW-1:0]   rf_raddr_b,
    output logic [RF_AW-1:0]   rf_waddr,
    output logic               rf_we,
    output logic               rf_wsrc,
    output logic               alu_op,
    output logic               alu_b_imm,
    output logic [IMM_W-1:0]   imm,
    output logic [DADDR_W-1:0] dm_addr,
    output logic               dm_we,
    output logic               busy,
    output logic               illegal
);

    state_t             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] dec_in_d;
    dp_t                dp_q;
    logic               dm_we_q;
    logic               rf_we_q;
    logic               busy_q;
    logic               illegal_q;
    ctrl_t              ctrl_d;

    // One decoder serves both phases: the memory bus in DECODE (so the selects
    // can be registered for EXEC), the latched IR afterwards
    always_comb begin
        dec_in_d = ir_q;
        if (state_q == DECODE) begin
            dec_in_d = instruction;
        end else begin
            dec_in_d = ir_q;
        end
    end

    instr_decoder u_dec (
        .instr_i (dec_in_d),
        .ctrl_o  (ctrl_d)
    );

    // Sequencer FSM with PC, IR and registered strobe/select outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            dp_q      <= DP_IDLE;
            dm_we_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run || step) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                FETCH: begin
                    state_q <= DECODE;
                end
                DECODE: begin
                    ir_q    <= instruction;
                    dp_q    <= ctrl_d.dp;
                    dm_we_q <= ctrl_d.dm_we;
                    state_q <= EXEC;
                end
                EXEC: begin
                    dm_we_q <= 1'b0;
                    if (ctrl_d.illegal) begin
                        illegal_q <= 1'b1;
                        dp_q      <= DP_IDLE;
                        busy_q    <= 1'b0;
                        state_q   <= HALT;
                    end else begin
                        pc_q    <= ctrl_d.jump ? ctrl_d.jmp_target : pc_inc(pc_q);
                        rf_we_q <= ctrl_d.rf_we;
                        state_q <= WB;
                    end
                end
                WB: begin
                    rf_we_q <= 1'b0;
                    dp_q    <= DP_IDLE;
                    if (run) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                    busy_q  <= 1'b0;
                    dm_we_q <= 1'b0;
                    rf_we_q <= 1'b0;
                    dp_q    <= DP_IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dm_we_q <= 1'b0;
                    rf_we_q <= 1'b0;
                    dp_q    <= DP_IDLE;
                end
            endcase
        end
    end

    assign pc         = pc_q;
    assign rf_raddr_a = dp_q.rf_raddr_a;
    assign rf_raddr_b = dp_q.rf_raddr_b;
    assign rf_waddr   = dp_q.rf_waddr;
    assign rf_wsrc    = dp_q.rf_wsrc;
    assign alu_op     = dp_q.alu_op;
    assign alu_b_imm  = dp_q.alu_b_imm;
    assign imm        = dp_q.imm;
    assign dm_addr    = dp_q.dm_addr;
    assign dm_we      = dm_we_q;
    assign rf_we      = rf_we_q;
    assign busy       = busy_q;
    assign illegal    = illegal_q;

endmodule
